// File: rtl/mm_sched.sv
// rtl/mm_sched.sv - round-robin scheduler sharing one pipelined ModMult among NUM_REQ requesters
module mm_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MULT_LAT   = 9,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          hold,
    output logic [DATA_WIDTH-1:0]         mm_a,
    output logic [DATA_WIDTH-1:0]         mm_b,
    input  logic [DATA_WIDTH-1:0]         mm_c,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [$clog2(MULT_LAT+2)-1:0] inflight,
    output logic                          idle
);

    localparam int CNT_W = $clog2(MULT_LAT + 2);
    // Issue register stage (aligned with mm_a/mm_b) followed by MULT_LAT ModMult stages.
    localparam int TAG_N = MULT_LAT + 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic             transfer;
    logic [TAG_N-1:0] tag_v;
    logic [ID_W-1:0]  tag_id [TAG_N];

    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign transfer  = grant_any && !hold;
    assign req_ready = transfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign idle      = (inflight == '0) && !(|req_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            mm_a   <= '0;
            mm_b   <= '0;
        end else if (transfer) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            mm_a   <= req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
            mm_b   <= req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int j = 0; j < TAG_N; j++) begin
                tag_id[j] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[TAG_N-2:0], transfer};
            tag_id[0] <= grant_id;
            for (int j = 1; j < TAG_N; j++) begin
                tag_id[j] <= tag_id[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_v[TAG_N-1];
            if (tag_v[TAG_N-1]) begin
                rsp_id   <= tag_id[TAG_N-1];
                rsp_data <= mm_c;
            end
        end
    end

    // A returning tag and a new transfer on the same edge cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({transfer, tag_v[TAG_N-1]})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_sched.sv
// tb/tb_mm_sched.sv - directed and random checks of mm_sched against a queue-based reference model
module tb_mm_sched;

    localparam int DW   = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 9;
    localparam int IDW  = 2;
    localparam logic [63:0] Q = 64'h0000_0000_FFFF_FFFB;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              hold;
    logic [DW-1:0]     mm_a;
    logic [DW-1:0]     mm_b;
    logic [DW-1:0]     mm_c;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic [3:0]        inflight;
    logic              idle;

    logic [DW-1:0]     mod_pipe [LAT];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          m_rr   = 0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic [31:0] m_rsp_data = '0;
    int          max_inf;
    exp_t        q_exp [$];

    mm_sched #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .MULT_LAT(LAT), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .hold(hold), .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mulmod(logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = ({32'b0, a} * {32'b0, b}) % Q;
        return p[31:0];
    endfunction

    // Behavioural ModMult: LAT register stages behind the registered operands.
    always @(posedge clk) begin
        mod_pipe[0] <= mulmod(mm_a, mm_b);
        for (int j = 1; j < LAT; j++) mod_pipe[j] <= mod_pipe[j-1];
    end
    assign mm_c = mod_pipe[LAT-1];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // One clock: check the grant before the edge, then update the model and check outputs after it.
    task automatic cycle();
        int          g;
        int          idx;
        logic [3:0]  exp_ready;
        logic [31:0] ga;
        logic [31:0] gb;
        bit          exp_v;
        int          exp_id;
        #2;
        g = -1;
        if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
        check("req_ready", {60'b0, req_ready}, {60'b0, exp_ready});
        if (g >= 0) begin
            ga = req_a[g*DW +: DW];
            gb = req_b[g*DW +: DW];
        end else begin
            ga = '0;
            gb = '0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            q_exp.delete();
            m_rr = 0;
            m_a = '0;
            m_b = '0;
            m_rsp_data = '0;
            check("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
            check("reset_inflight", {60'b0, inflight}, 64'd0);
        end else begin
            exp_v  = 1'b0;
            exp_id = 0;
            if (q_exp.size() > 0 && q_exp[0].due == cyc) begin
                exp_v      = 1'b1;
                exp_id     = q_exp[0].id;
                m_rsp_data = q_exp[0].data;
                void'(q_exp.pop_front());
            end
            if (g >= 0) begin
                q_exp.push_back('{id: g, data: mulmod(ga, gb), due: cyc + LAT + 1});
                m_rr = (g + 1) % NREQ;
                m_a  = ga;
                m_b  = gb;
            end
            check("rsp_valid", {63'b0, rsp_valid}, {63'b0, exp_v});
            if (exp_v) check("rsp_id", {62'b0, rsp_id}, 64'(exp_id));
            check("rsp_data", {32'b0, rsp_data}, {32'b0, m_rsp_data});
            check("inflight", {60'b0, inflight}, 64'(q_exp.size()));
        end
        check("mm_a", {32'b0, mm_a}, {32'b0, m_a});
        check("mm_b", {32'b0, mm_b}, {32'b0, m_b});
        check("idle", {63'b0, idle}, {63'b0, (q_exp.size() == 0) && (req_valid == '0)});
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        do_reset(3);
        check("idle_after_reset", {63'b0, idle}, 64'd1);

        // Single op: req0 A=3 B=5, product after MULT_LAT+1 edges, for one cycle.
        repeat (5) cycle();
        req_valid = 4'b0001;
        set_req(0, 32'd3, 32'd5);
        cycle();
        check("single_mm_a", {32'b0, mm_a}, 64'd3);
        check("single_mm_b", {32'b0, mm_b}, 64'd5);
        req_valid = '0;
        repeat (LAT + 1) cycle();
        check("single_rsp_valid", {63'b0, rsp_valid}, 64'd1);
        check("single_rsp_id", {62'b0, rsp_id}, 64'd0);
        check("single_rsp_data", {32'b0, rsp_data}, 64'd15);
        cycle();
        check("single_rsp_once", {63'b0, rsp_valid}, 64'd0);
        check("single_inflight", {60'b0, inflight}, 64'd0);

        // All four requesters continuously from rr_ptr=0.
        do_reset(1);
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom % 32'hFFFF_FFFB, $urandom % 32'hFFFF_FFFB);
        max_inf = 0;
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
        end
        check("inflight_saturates", 64'(max_inf), 64'(LAT + 1));
        req_valid = '0;
        repeat (LAT + 2) cycle();

        // Single requester 2, A=i, B=2, granted every cycle.
        req_valid = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            set_req(2, 32'(i), 32'd2);
            cycle();
        end
        req_valid = '0;
        repeat (LAT + 2) cycle();

        // hold with three ops in flight and req1 waiting.
        req_valid = 4'b0001;
        repeat (3) cycle();
        req_valid = 4'b0010;
        set_req(1, 32'd7, 32'd9);
        hold = 1'b1;
        repeat (5) cycle();
        hold = 1'b0;
        #2;
        check("grant_after_hold", {60'b0, req_ready}, 64'b0010);
        cycle();
        req_valid = '0;
        repeat (LAT + 2) cycle();

        // Reset with four ops in flight; none may return.
        req_valid = 4'b1111;
        repeat (4) cycle();
        req_valid = '0;
        repeat (4) cycle();
        do_reset(1);
        repeat (LAT + 3) cycle();
        check("idle_after_midreset", {63'b0, idle}, 64'd1);
        req_valid = 4'b1111;
        #2;
        check("first_grant_after_reset", {60'b0, req_ready}, 64'b0001);
        cycle();
        req_valid = '0;
        repeat (LAT + 2) cycle();

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) set_req(i, $urandom % 32'hFFFF_FFFB, $urandom % 32'hFFFF_FFFB);
            hold  = ($urandom % 8) == 0;
            reset = ($urandom % 1000) == 0;
            cycle();
        end
        reset     = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        repeat (LAT + 3) cycle();
        check("drained", 64'(q_exp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
